// File: rtl/quant_pkg.sv
// Shared quantizer constants and the tile-drain FSM state encoding.
package quant_pkg;

  localparam int Q_OUT_W = 32;
  localparam logic signed [Q_OUT_W-1:0] Q_MAX = {1'b0, {(Q_OUT_W-1){1'b1}}};
  localparam logic signed [Q_OUT_W-1:0] Q_MIN = {1'b1, {(Q_OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/quantize_scheduler_if.sv
// Accumulator-row input and quantized-row output handshake bundle.
interface quantize_scheduler_if #(
  parameter int ARRAY_SIZE = 32,
  parameter int IN_W       = 133,
  parameter int OUT_W      = 32,
  parameter int ROW_W      = 6
);
  logic                        acc_valid;
  logic                        acc_ready;
  logic [ARRAY_SIZE*IN_W-1:0]  acc_data;
  logic                        q_valid;
  logic                        q_ready;
  logic [ARRAY_SIZE*OUT_W-1:0] q_data;
  logic [ROW_W-1:0]            q_row_idx;
  logic [ARRAY_SIZE-1:0]       q_sat;

  modport master (
    output acc_valid, acc_data, q_ready,
    input  acc_ready, q_valid, q_data, q_row_idx, q_sat
  );

  modport slave (
    input  acc_valid, acc_data, q_ready,
    output acc_ready, q_valid, q_data, q_row_idx, q_sat
  );
endinterface

// File: rtl/quantize_lane.sv
// One quantizer lane: runtime arithmetic shift with round-half-up (S1), then
// saturation to the signed output range (S2). Both stages hold when i_en is low.
module quantize_lane
  import quant_pkg::*;
#(
  parameter int IN_W    = 133,
  parameter int OUT_W   = Q_OUT_W,
  parameter int SHIFT_W = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_en,
  input  logic [SHIFT_W-1:0]        i_shift,
  input  logic signed [IN_W-1:0]    i_data,
  output logic signed [OUT_W-1:0]   o_q,
  output logic                      o_sat
);

  localparam logic signed [IN_W:0] MAX_X = (IN_W+1)'(Q_MAX);
  localparam logic signed [IN_W:0] MIN_X = (IN_W+1)'(Q_MIN);

  // One guard bit above IN_W keeps shifted-value + round bit from overflowing.
  function automatic logic signed [IN_W:0] scale_round(input logic signed [IN_W-1:0] d,
                                                       input logic [SHIFT_W-1:0]     sh);
    logic signed [IN_W:0] ext;
    logic                 rb;
    ext = (IN_W+1)'(d);
    rb  = (sh == '0) ? 1'b0 : d[sh - 1'b1];
    return (ext >>> sh) + $signed({{IN_W{1'b0}}, rb});
  endfunction

  function automatic logic [OUT_W:0] saturate(input logic signed [IN_W:0] v);
    if (v > MAX_X) return {1'b1, Q_MAX};
    if (v < MIN_X) return {1'b1, Q_MIN};
    return {1'b0, v[OUT_W-1:0]};
  endfunction

  logic signed [IN_W:0]  r_s1_p1;
  logic signed [OUT_W-1:0] r_q_p2;
  logic                  r_sat_p2;

  // Stage 1: scale and round
  always_ff @(posedge clk) begin
    if (i_en) r_s1_p1 <= scale_round(i_data, i_shift);
  end

  // Stage 2: clamp
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q_p2   <= '0;
      r_sat_p2 <= 1'b0;
    end else if (i_en) begin
      {r_sat_p2, r_q_p2} <= saturate(r_s1_p1);
    end
  end

  assign o_q   = r_q_p2;
  assign o_sat = r_sat_p2;

endmodule

// File: rtl/quantize_scheduler.sv
// Tile-drain sequencer: accepts cfg_rows accumulator rows, quantizes them through
// ARRAY_SIZE two-stage lanes and emits indexed rows, pulsing done after the last one.
module quantize_scheduler
  import quant_pkg::*;
#(
  parameter int ARRAY_SIZE = 32,
  parameter int IN_W       = 133,
  parameter int OUT_W      = 32,
  parameter int SHIFT_W    = 8,
  parameter int ROW_W      = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_start,
  input  logic [SHIFT_W-1:0] cfg_shift,
  input  logic [ROW_W-1:0]   cfg_rows,
  output logic               cfg_err,
  output logic               busy,
  output logic               done,
  quantize_scheduler_if.slave bus
);

  state_e             r_state, w_next;
  logic [SHIFT_W-1:0] r_shift;
  logic [ROW_W-1:0]   r_rows, r_in_cnt, r_row_idx;
  logic               r_vld_p1, r_q_valid, r_cfg_err;
  logic               w_stall, w_en, w_acc_rdy, w_acc_fire, w_q_fire, w_start, w_shift_ok;

  assign w_stall    = r_q_valid & ~bus.q_ready;
  assign w_en       = ~w_stall;
  assign w_acc_rdy  = (r_state == RUN) && (r_in_cnt < r_rows) && !w_stall;
  assign w_acc_fire = bus.acc_valid & w_acc_rdy;
  assign w_q_fire   = r_q_valid & bus.q_ready;
  assign w_start    = (r_state == IDLE) & cfg_start;
  assign w_shift_ok = 32'(cfg_shift) < 32'(IN_W);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_start && w_shift_ok) w_next = (cfg_rows == '0) ? DONE : RUN;
      RUN:     if (r_in_cnt == r_rows) w_next = DRAIN;
      DRAIN:   if (w_q_fire && (r_row_idx == r_rows - 1'b1)) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_rows    <= '0;
      r_in_cnt  <= '0;
      r_row_idx <= '0;
      r_vld_p1  <= 1'b0;
      r_q_valid <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_cfg_err <= w_start & ~w_shift_ok;
      if (w_start && w_shift_ok) begin
        r_shift   <= cfg_shift;
        r_rows    <= cfg_rows;
        r_in_cnt  <= '0;
        r_row_idx <= '0;
      end else begin
        if (w_acc_fire) r_in_cnt  <= r_in_cnt + 1'b1;
        if (w_q_fire)   r_row_idx <= r_row_idx + 1'b1;
      end
      // Whole pipeline moves together so a stall never drops or duplicates a row.
      if (w_en) begin
        r_vld_p1  <= w_acc_fire;
        r_q_valid <= r_vld_p1;
      end
    end
  end

  for (genvar gi = 0; gi < ARRAY_SIZE; gi++) begin : g_lane
    logic signed [OUT_W-1:0] w_q;
    quantize_lane #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT_W(SHIFT_W)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .i_en    (w_en),
      .i_shift (r_shift),
      .i_data  (bus.acc_data[gi*IN_W +: IN_W]),
      .o_q     (w_q),
      .o_sat   (bus.q_sat[gi])
    );
    assign bus.q_data[gi*OUT_W +: OUT_W] = w_q;
  end

  assign bus.acc_ready = w_acc_rdy;
  assign bus.q_valid   = r_q_valid;
  assign bus.q_row_idx = r_row_idx;
  assign cfg_err       = r_cfg_err;
  assign busy          = (r_state != IDLE);
  assign done          = (r_state == DONE);

endmodule

// File: tb/tb_quantize_scheduler.sv
// Scoreboard bench for quantize_scheduler: rows are modelled when accepted and
// compared lane by lane when the quantized row is handshaken.
module tb_quantize_scheduler;

  localparam int AS = 32;
  localparam int IW = 133;
  localparam int OW = 32;
  localparam int SW = 8;
  localparam int RW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_start;
  logic [SW-1:0] cfg_shift;
  logic [RW-1:0] cfg_rows;
  logic          cfg_err, busy, done;

  always #5 clk = ~clk;

  quantize_scheduler_if #(.ARRAY_SIZE(AS), .IN_W(IW), .OUT_W(OW), .ROW_W(RW)) bus ();

  quantize_scheduler #(.ARRAY_SIZE(AS), .IN_W(IW), .OUT_W(OW), .SHIFT_W(SW), .ROW_W(RW)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_start (cfg_start),
    .cfg_shift (cfg_shift),
    .cfg_rows  (cfg_rows),
    .cfg_err   (cfg_err),
    .busy      (busy),
    .done      (done),
    .bus       (bus.slave)
  );

  typedef struct {
    logic [RW-1:0]    idx;
    logic [AS*OW-1:0] q;
    logic [AS-1:0]    sat;
    int               cyc;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0, n_fail = 0, cyc = 0, done_cnt = 0, exp_idx = 0, cur_shift = 0;
  bit   bp_mode = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference quantizer: floor((v + 2^(sh-1)) / 2^sh), then clamp.
  function automatic logic [OW:0] model_q(input logic signed [IW-1:0] v, input int sh);
    logic signed [IW+1:0] w, one, mx, mn;
    one = (IW+2)'(1);
    mx  = (IW+2)'(64'sh7FFFFFFF);
    mn  = (IW+2)'(-64'sh80000000);
    w   = (IW+2)'(v);
    if (sh > 0) w = (w + (one <<< (sh - 1))) >>> sh;
    if (w > mx) return {1'b1, mx[OW-1:0]};
    if (w < mn) return {1'b1, mn[OW-1:0]};
    return {1'b0, w[OW-1:0]};
  endfunction

  function automatic logic [AS*IW-1:0] rand_row();
    logic [AS*IW-1:0]     r;
    logic signed [IW-1:0] x;
    for (int l = 0; l < AS; l++) begin
      x = IW'($signed({$urandom, $urandom}));
      x = x >>> $urandom_range(0, 63);
      r[l*IW +: IW] = x;
    end
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    bus.q_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bp_mode) bus.q_ready = ~bus.q_ready;
      else         bus.q_ready = 1'b1;
    end
  end

  // Output monitor
  initial begin
    exp_t             e;
    bit               prev_stall;
    logic [AS*OW-1:0] prev_q;
    logic [RW-1:0]    prev_idx;
    logic [AS-1:0]    prev_sat;
    prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (done) done_cnt++;
        if (prev_stall) begin
          chk("hold_q_lane0", bus.q_data[OW-1:0], prev_q[OW-1:0]);
          chk("hold_q_lane1", bus.q_data[2*OW-1:OW], prev_q[2*OW-1:OW]);
          chk("hold_idx", bus.q_row_idx, prev_idx);
          chk("hold_sat", bus.q_sat, prev_sat);
          chk("hold_valid", bus.q_valid, 1);
        end
        if (bus.q_valid && !bus.q_ready) chk("stall_acc_ready", bus.acc_ready, 0);
        if (bus.q_valid && bus.q_ready) begin
          if (sb.size() == 0) begin
            chk("q_unexpected", bus.q_row_idx + 64'd1, 0);
          end else begin
            e = sb.pop_front();
            chk("q_row_idx", bus.q_row_idx, e.idx);
            for (int l = 0; l < AS; l++)
              chk($sformatf("q_lane%0d", l), bus.q_data[l*OW +: OW], e.q[l*OW +: OW]);
            chk("q_sat", bus.q_sat, e.sat);
            if (!bp_mode) chk("latency", 64'(cyc - e.cyc), 2);
          end
        end
        prev_stall = bus.q_valid && !bus.q_ready;
        prev_q     = bus.q_data;
        prev_idx   = bus.q_row_idx;
        prev_sat   = bus.q_sat;
      end
    end
  end

  task automatic start_tile(input int sh, input int rows);
    cfg_start = 1'b1;
    cfg_shift = SW'(sh);
    cfg_rows  = RW'(rows);
    cur_shift = sh;
    exp_idx   = 0;
    @(posedge clk);
    #1;
    cfg_start = 1'b0;
  endtask

  task automatic send_row(input logic [AS*IW-1:0] row);
    int           t;
    exp_t         e;
    logic [OW:0]  m;
    bus.acc_valid = 1'b1;
    bus.acc_data  = row;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!bus.acc_ready && t < 200);
    if (!bus.acc_ready) begin
      chk("acc_timeout", bus.acc_ready, 1);
    end else begin
      e.idx = RW'(exp_idx);
      exp_idx++;
      e.cyc = cyc;
      for (int l = 0; l < AS; l++) begin
        m = model_q($signed(row[l*IW +: IW]), cur_shift);
        e.sat[l]         = m[OW];
        e.q[l*OW +: OW]  = m[OW-1:0];
      end
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.acc_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int t, d0;
    d0 = done_cnt;
    t  = 0;
    while (done_cnt == d0 && t < 400) begin
      @(posedge clk);
      t++;
    end
    #1;
    repeat (3) @(posedge clk);
    #1;
    chk(tag, 64'(done_cnt - d0), 1);
  endtask

  initial begin
    logic [AS*IW-1:0] r;
    int               d0;
    rst = 1'b1; cfg_start = 1'b0; cfg_shift = '0; cfg_rows = '0;
    bus.acc_valid = 1'b0; bus.acc_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_q_valid", bus.q_valid, 0);
    chk("rst_acc_ready", bus.acc_ready, 0);
    chk("rst_row_idx", bus.q_row_idx, 0);
    chk("rst_q_sat", bus.q_sat, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic tile
    start_tile(4, 3);
    r = rand_row(); r[IW-1:0] = IW'(24);  send_row(r);
    r = rand_row(); r[IW-1:0] = IW'(23);  send_row(r);
    r = rand_row(); r[IW-1:0] = IW'(-24); send_row(r);
    wait_done("t1_done");

    // Saturation both ways
    start_tile(0, 1);
    r = '0;
    r[IW-1:0]    = IW'(64'sd1 <<< 40);
    r[2*IW-1:IW] = IW'(-(64'sd1 <<< 40));
    send_row(r);
    wait_done("t2_done");

    // Backpressure
    bp_mode = 1'b1;
    start_tile(3, 8);
    for (int i = 0; i < 8; i++) send_row(rand_row());
    wait_done("t3_done");
    bp_mode = 1'b0;
    @(posedge clk);
    #1;

    // Rejected shift
    cfg_start = 1'b1; cfg_shift = SW'(133); cfg_rows = RW'(4);
    @(posedge clk);
    #1;
    cfg_start = 1'b0;
    @(negedge clk);
    chk("err_pulse", cfg_err, 1);
    chk("err_busy", busy, 0);
    @(negedge clk);
    chk("err_clear", cfg_err, 0);
    chk("err_busy2", busy, 0);
    @(posedge clk);
    #1;

    // Largest legal shift
    start_tile(132, 1);
    send_row(rand_row());
    wait_done("t4_max_shift_done");

    // Empty tile
    start_tile(2, 0);
    @(negedge clk);
    chk("rows0_done", done, 1);
    chk("rows0_busy", busy, 1);
    @(negedge clk);
    chk("rows0_done_clear", done, 0);
    chk("rows0_busy_clear", busy, 0);
    @(posedge clk);
    #1;

    // Start while busy is ignored
    start_tile(2, 2);
    send_row(rand_row());
    cfg_start = 1'b1; cfg_shift = SW'(0); cfg_rows = RW'(5);
    @(posedge clk);
    #1;
    cfg_start = 1'b0;
    send_row(rand_row());
    wait_done("t4_ignore_done");

    // Reset mid-tile
    start_tile(1, 5);
    send_row(rand_row());
    send_row(rand_row());
    d0 = done_cnt;
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_q_valid", bus.q_valid, 0);
    chk("mid_rst_acc_ready", bus.acc_ready, 0);
    chk("mid_rst_idx", bus.q_row_idx, 0);
    chk("mid_rst_q_lane0", bus.q_data[OW-1:0], 0);
    chk("mid_rst_q_sat", bus.q_sat, 0);
    chk("mid_rst_done", done, 0);
    sb.delete();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_no_done", 64'(done_cnt), 64'(d0));
    start_tile(4, 1);
    send_row(rand_row());
    wait_done("t5_restart_done");

    // Round half up
    start_tile(1, 3);
    r = rand_row(); r[IW-1:0] = IW'(3);  send_row(r);
    r = rand_row(); r[IW-1:0] = IW'(-3); send_row(r);
    r = rand_row(); r[IW-1:0] = IW'(2);  send_row(r);
    wait_done("t6_done");

    chk("sb_empty", 64'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
